// File: rtl/mmm_nlp_modinv.sv
// Modular inverse X = A^-1 mod N by the binary extended Euclid method.
// One operation in flight; result held in DONE until the consumer takes it.
module mmm_nlp_modinv #(
    parameter int DW     = 256,
    parameter int MAXCYC = 4*DW+4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_n,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_inv,
    output logic          o_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CHK  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int            CW   = $clog2(MAXCYC+1);
    localparam logic [CW-1:0] CMAX = CW'(MAXCYC);

    logic [1:0]    state;
    logic [DW-1:0] a_q;
    logic [DW-1:0] n_q;
    logic [DW-1:0] u;
    logic [DW-1:0] v;
    logic [DW-1:0] res;
    logic [DW:0]   x1;
    logic [DW:0]   x2;
    logic [DW:0]   nx;
    logic [DW:0]   x1_half;
    logic [DW:0]   x2_half;
    logic [DW:0]   x1_sub;
    logic [DW:0]   x2_sub;
    logic [CW-1:0] cnt;
    logic          bad;
    logic          illegal;

    assign o_ready = (state == IDLE);
    assign nx      = {1'b0, n_q};
    assign illegal = !n_q[0] || (n_q < DW'(3)) ||
                     (a_q == '0) || (a_q >= n_q);

    // x < N < 2^DW, so x+N always fits in DW+1 bits
    always_comb begin
        x1_half = x1[0] ? ((x1 + nx) >> 1) : (x1 >> 1);
        x2_half = x2[0] ? ((x2 + nx) >> 1) : (x2 >> 1);
        x1_sub  = (x1 >= x2) ? (x1 - x2) : (x1 + nx - x2);
        x2_sub  = (x2 >= x1) ? (x2 - x1) : (x2 + nx - x1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            a_q     <= '0;
            n_q     <= '0;
            u       <= '0;
            v       <= '0;
            x1      <= '0;
            x2      <= '0;
            res     <= '0;
            cnt     <= '0;
            bad     <= 1'b0;
            o_valid <= 1'b0;
            o_inv   <= '0;
            o_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q   <= i_a;
                        n_q   <= i_n;
                        u     <= i_a;
                        v     <= i_n;
                        x1    <= (DW+1)'(1);
                        x2    <= '0;
                        res   <= '0;
                        bad   <= 1'b0;
                        state <= CHK;
                    end
                end
                CHK: begin
                    cnt <= '0;
                    if (illegal) begin
                        bad   <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CMAX) begin
                        bad   <= 1'b1;
                        state <= DONE;
                    end else if (u == DW'(1)) begin
                        res   <= x1[DW-1:0];
                        state <= DONE;
                    end else if (v == DW'(1)) begin
                        res   <= x2[DW-1:0];
                        state <= DONE;
                    end else if (u == '0 || v == '0) begin
                        bad   <= 1'b1;
                        state <= DONE;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= x1_half;
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= x2_half;
                    end else if (u >= v) begin
                        u  <= u - v;
                        x1 <= x1_sub;
                    end else begin
                        v  <= v - u;
                        x2 <= x2_sub;
                    end
                end
                DONE: begin
                    // first DONE cycle publishes the result registers
                    if (!o_valid) begin
                        o_valid <= 1'b1;
                        o_err   <= bad;
                        o_inv   <= bad ? '0 : res;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                        o_err   <= 1'b0;
                        o_inv   <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mmm_nlp_modinv.md
MMM_NLP_MODINV -- requirements
Module: mmm_nlp_modinv

Interface
REQ-001 Parameter DW, default 256: operand and result width in bits.
REQ-002 Parameter MAXCYC, default 4*DW+4: cycle-count watchdog limit for one inversion.
REQ-003 i_clk  in  1  the only clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous and active-high.
REQ-005 i_valid  in  1  request strobe; i_a and i_n are qualified by it.
REQ-006 o_ready  out  1  block idle; a request is accepted on a rising edge where i_valid && o_ready.
REQ-007 i_a  in  DW  value to invert.
REQ-008 i_n  in  DW  modulus.
REQ-009 o_valid  out  1  result available; held until accepted.
REQ-010 i_ready  in  1  result consumer ready; the result is accepted on a rising edge where o_valid && i_ready.
REQ-011 o_inv  out  DW  X with (A*X) mod N = 1; 0 when o_err=1.
REQ-012 o_err  out  1  no inverse exists or the operands are illegal; qualified by o_valid.

Function
REQ-013 The block shall compute X = A^-1 mod N by the binary extended Euclid method, with registers u, v (DW bits) and x1, x2 (DW+1 bits).
REQ-014 The FSM shall have exactly four states: IDLE, CHK, RUN and DONE.
REQ-015 IDLE: o_ready=1; on accept, latch A and N, load u=A, v=N, x1=1, x2=0, and go to CHK.
REQ-016 CHK, one cycle: if N is even, N<3, A=0 or A>=N, set err=1 and go to DONE; otherwise go to RUN.
REQ-017 RUN shall perform exactly one action per cycle, in this priority order:
  (a) u==1: result=x1, go to DONE;
  (b) v==1: result=x2, go to DONE;
  (c) u==0 or v==0: err=1, go to DONE;
  (d) u even: u=u>>1; x1=x1>>1 if x1 even, else (x1+N)>>1;
  (e) v even: the same operation on v and x2;
  (f) u>=v: u=u-v; x1=x1-x2, plus N if the difference is negative;
  (g) otherwise: v=v-u; x2=x2-x1, plus N if negative.
REQ-018 Arithmetic rules:
  - x1 and x2 shall remain in [0, N-1] after every step.
  - The intermediate x+N is DW+1 bits wide and shall never truncate.
REQ-019 An internal cycle counter shall clear on entry to RUN; if it reaches MAXCYC, set err=1 and go to DONE.
REQ-020 DONE:
  - o_valid=1, o_ready=0; o_inv and o_err shall be stable.
  - On accept, go to IDLE with o_valid=0 on the following cycle.
REQ-021 With i_ready low, DONE shall hold indefinitely, and i_valid shall be ignored while o_ready=0.
REQ-022 o_inv shall be registered and driven 0 whenever o_err=1 or o_valid=0.
REQ-023 Latency, counted from the accept edge k:
  - illegal operand: o_valid rises after edge k+2;
  - A=1: o_valid rises after edge k+3;
  - in general: o_valid rises no later than after edge k+MAXCYC+3.
REQ-024 Throughput: one operation in flight; the next accept is possible on the first edge after result acceptance.
REQ-025 Operand inputs shall be ignored after the accept edge; changes on i_a or i_n mid-operation shall not affect the result.

Reset
REQ-026 Asserting i_rst shall immediately force:
  - state=IDLE;
  - o_ready=1, o_valid=0, o_err=0, o_inv=0;
  - u, v, x1, x2 and the cycle counter to 0.
REQ-027 Reset asserted mid-RUN or in DONE shall discard the operation, with no o_valid pulse after release.
REQ-028 After release, the first rising edge shall be able to accept a request.

Verification
REQ-029 Basic inverse: A=3, N=7 -> o_valid with o_inv=5, o_err=0; A=1, N=7 -> o_inv=1 after edge k+3.
REQ-030 Wide inverse: N=2^DW-1, A=2 -> o_inv=2^(DW-1), o_err=0; also A=N-1 -> o_inv=N-1.
REQ-031 Errors:
  - A=6, N=9 (gcd 3) -> o_err=1, o_inv=0;
  - N=10 -> o_err=1 after edge k+2;
  - A=0 and A>=N -> o_err=1.
REQ-032 Backpressure: i_ready held low 20 cycles after o_valid -> o_inv and o_err stable, o_ready=0, second i_valid ignored; the result is accepted once i_ready rises.
REQ-033 Reset mid-operation: i_rst pulsed while in RUN with A=5, N=2^DW-1 -> outputs reach their reset values at once; the next request A=3, N=7 returns 5.
REQ-034 Random check: 1000 random odd N and random A<N, compared against a golden model -> A*o_inv mod N=1 whenever gcd=1, otherwise o_err=1; every latency <= MAXCYC+3.
